// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, widths and FSM states.
// ALU control imports alu_type_e from here so both sides agree on the encoding.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative 1-bit-per-cycle shifter with its own shift register and down-counter.
// value is the register after this cycle's step, so the final result is ready when done.
module alu_shifter
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_W-1:0]   src,
    input  logic [SHAMT_W-1:0]  shamt,
    input  alu_type_e           mode,
    output logic                done,
    output logic [DATA_W-1:0]   value
);

    logic [DATA_W-1:0]  shreg;
    logic [SHAMT_W-1:0] count;
    alu_type_e          mode_q;
    logic [DATA_W-1:0]  step;

    always_comb begin
        step = shreg;
        case (mode_q)
            ALU_SLL: step = {shreg[DATA_W-2:0], 1'b0};
            ALU_SRL: step = {1'b0, shreg[DATA_W-1:1]};
            ALU_SRA: step = {shreg[DATA_W-1], shreg[DATA_W-1:1]};
            default: step = shreg;
        endcase
    end

    // Data register is not reset; the counter alone decides whether it matters.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg  <= src;
            mode_q <= mode;
        end else if (count != '0) begin
            shreg <= step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= shamt;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done  = (count == SHAMT_W'(1));
    assign value = step;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/sub/logic/compare, iterative shifts,
// valid/ready on both sides and a registered result with zero flag.
module alu_exec
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALUType,
    input  logic [DATA_W-1:0]  src1,
    input  logic [DATA_W-1:0]  src2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero
);

    state_e              state;
    state_e              state_nxt;
    logic                accept;
    logic                shift_start;
    logic                load_direct;
    logic                shift_finish;
    logic                shift_done;
    logic [DATA_W-1:0]   shift_value;
    logic [DATA_W-1:0]   single_res;
    logic [SHAMT_W-1:0]  shamt;

    // Shift codes land here only when shamt is zero, so they pass src1 through.
    function automatic logic [DATA_W-1:0] alu_single(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic [DATA_W-1:0]        r;
        a_s = a;
        b_s = b;
        r   = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLL, ALU_SRL, ALU_SRA: r = a;
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign shamt        = src2[SHAMT_W-1:0];
    assign in_ready     = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept       = in_valid && in_ready;
    assign shift_start  = accept && is_shift(ALUType) && (shamt != '0);
    assign load_direct  = accept && !shift_start;
    assign shift_finish = (state == ST_SHIFT) && shift_done;
    assign single_res   = alu_single(ALUType, src1, src2);
    assign out_valid    = (state == ST_DONE);

    alu_shifter u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (shift_start),
        .src   (src1),
        .shamt (shamt),
        .mode  (alu_type_e'(ALUType)),
        .done  (shift_done),
        .value (shift_value)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (shift_start)      state_nxt = ST_SHIFT;
                else if (load_direct) state_nxt = ST_DONE;
            end
            ST_SHIFT: begin
                if (shift_done) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (shift_start)      state_nxt = ST_SHIFT;
                else if (load_direct) state_nxt = ST_DONE;
                else if (out_ready)   state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output register stage: result/zero only move on a load or a finished shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_direct) begin
                result <= single_res;
                zero   <= (single_res == '0);
            end else if (shift_finish) begin
                result <= shift_value;
                zero   <= (shift_value == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a vector table for single-cycle ops plus
// hand-written sequences for shifts, backpressure and reset mid-shift.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUType;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[12];

    alu_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUType   (ALUType),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one shift with out_ready high and measure latency to out_valid.
    task automatic run_shift(input string name, input logic [3:0] op, input logic [31:0] a,
                             input int k, input logic [31:0] exp);
        int n;
        logic busy_ready;
        in_valid  = 1'b1;
        ALUType   = op;
        src1      = a;
        src2      = 32'(k);
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid   = 1'b0;
        n          = 1;
        busy_ready = 1'b0;
        while (!out_valid && n < 40) begin
            busy_ready = busy_ready | in_ready;
            tick();
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(k + 1));
        chk({name, "_in_ready_busy"}, 32'(busy_ready), 32'd0);
        chk({name, "_result"}, result, exp);
        chk({name, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        tick();
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[1]  = '{4'd1,  32'd5,         32'd5,         32'd0,         1'b1};
        vecs[2]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1,         1'b0};
        vecs[3]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'd0,         1'b1};
        vecs[4]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'd1,         1'b0};
        vecs[5]  = '{4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{4'd5,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0};
        vecs[7]  = '{4'd8,  32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0};
        vecs[8]  = '{4'd9,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0,         1'b1};
        vecs[9]  = '{4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0,         1'b1};
        vecs[10] = '{4'd2,  32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0};
        vecs[11] = '{4'd7,  32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        ALUType   = 4'd0;
        src1      = '0;
        src2      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops: each result must appear one cycle after accept.
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1'b1;
            ALUType   = vecs[i].op;
            src1      = vecs[i].a;
            src2      = vecs[i].b;
            out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        run_shift("sra4", 4'd7, 32'h8000_0000, 4, 32'hF800_0000);
        run_shift("sll31", 4'd2, 32'h0000_0001, 31, 32'h8000_0000);
        run_shift("srl31", 4'd6, 32'h8000_0000, 31, 32'h0000_0001);
        run_shift("srl3", 4'd6, 32'hF000_000F, 3, 32'h1E00_0001);

        // Backpressure: result held while out_ready is low, then back-to-back accept.
        in_valid  = 1'b1;
        ALUType   = 4'd9;
        src1      = 32'hF0F0_F0F0;
        src2      = 32'hFF00_FF00;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_result", c), result, 32'hF000_F000);
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b1;
        ALUType   = 4'd8;
        src1      = 32'd1;
        src2      = 32'd2;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_out_valid", 32'(out_valid), 32'd1);
        chk("bp_next_result", result, 32'd3);
        tick();

        // Reset during the second cycle of an SRL by 10.
        in_valid = 1'b1;
        ALUType  = 4'd6;
        src1     = 32'hFFFF_FFFF;
        src2     = 32'd10;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        begin
            logic stale;
            stale = 1'b0;
            for (int c = 0; c < 15; c++) begin
                tick();
                stale = stale | out_valid | (result != 32'd0);
            end
            chk("midrst_no_stale", 32'(stale), 32'd0);
        end

        run_shift("sll1_after_rst", 4'd2, 32'h4000_0001, 1, 32'h8000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU that consumes the 4-bit ALUType code produced by the ALU control unit plus two 32-bit operands, and returns a registered result with a zero flag. Add/sub/logic/compare finish in one cycle. Shifts use a 1-bit-per-cycle iterative shifter to save area. A valid/ready handshake on both sides lets the pipeline controller stall ID/EX while a shift is in flight.

## Interface
- DATA_W, 32, operand/result width; must be 32 for RV32I shift semantics.
- SHAMT_W, 5, shift-amount width (log2 DATA_W).

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and ALUType valid this cycle
- in_ready  out  1  block can accept an operation this cycle
- ALUType  in  4  operation code from ALU control (encoding in alu_pkg)
- src1  in  DATA_W  operand A (value being shifted for shifts)
- src2  in  DATA_W  operand B; bits [4:0] are shamt for shifts
- out_valid  out  1  result/zero valid
- out_ready  in  1  consumer accepts result this cycle
- result  out  DATA_W  registered result
- zero  out  1  registered flag, high when result == 0

## Operation
- ALUType encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9. Codes 10–15 are illegal and produce result 0, zero=1, with latency 1.
- ADD/SUB wrap modulo 2^32; no overflow or carry output.
- SLT compares signed, SLTU compares unsigned; the result is 32'd1 or 32'd0.
- SRA fills with src1[31]; SRL and SLL fill with 0. src2[31:5] are ignored for shifts.
- FSM states:
  - IDLE: waiting for an operation.
  - SHIFT: iterating the shifter.
  - DONE: result held for the consumer.
- Accept occurs when in_valid && in_ready.
- From IDLE (or DONE with out_ready), on accept:
  - Non-shift, or shift with shamt=0: result loads directly; go to DONE.
  - Shift with shamt=k>0: the shifter loads src1, count=k; go to SHIFT.
- SHIFT: each cycle shift one bit and decrement count. When count reaches 1, write the final value to result and go to DONE. Inputs are ignored in SHIFT.
- DONE: out_valid=1; result and zero are held stable until out_ready.
  - out_ready with no new accept → IDLE.
  - out_ready with a simultaneous accept → next op starts (back-to-back).
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)). It is 0 throughout SHIFT.
- Reset, including mid-shift: state=IDLE, count=0, result=0, zero=0, out_valid=0, in_ready=0 while rst is high. The in-flight op is discarded.

## Timing
- Latency is measured from the accept edge N to the first cycle with out_valid=1:
  - non-shift/illegal/shamt=0: cycle N+1
  - shift with shamt=k: cycle N+1+k (max 32 cycles for k=31)
- Throughput is 1 op/cycle for single-cycle ops when out_ready stays high.
- in_ready depends combinationally on out_ready. out_valid, result and zero are purely registered.
- Output stability: while out_valid=1 and out_ready=0, result and zero must not change.

## Structure
- alu_pkg holds:
  - typedef enum logic [3:0] alu_type_e (the codes above); ALU control imports the same type.
  - DATA_W/SHAMT_W localparams.
  - the FSM state enum.
- Sub-module alu_shifter: the iterative shifter. It has load, src, shamt, mode (SLL/SRL/SRA), done and value. It owns the shift register and down-counter.
- alu_exec contains the single-cycle datapath, the FSM, the handshake and the output registers.

## Test plan
- Reset, then ADD src1=32'h7FFF_FFFF, src2=1 with out_ready=1 → out_valid in the next cycle, result=32'h8000_0000, zero=0.
- SUB 5-5 → result=0, zero=1. Then SLT src1=32'hFFFF_FFFF, src2=1 → 1. SLTU with the same operands → 0.
- SRA src1=32'h8000_0000, shamt=4 → out_valid exactly 5 cycles after accept, result=32'hF800_0000, in_ready=0 during the 4 SHIFT cycles. SLL 1<<31 → out_valid after 32 cycles, result=32'h8000_0000.
- Backpressure: AND 32'hF0F0_F0F0 & 32'hFF00_FF00 with out_ready=0 for 3 cycles → result=32'hF000_F000 held, in_ready=0. Then raise out_ready together with in_valid (OR 1|2) → back-to-back accept, next result=3.
- Reset asserted on the 2nd cycle of SRL shamt=10 → the following cycle has out_valid=0, result=0, in_ready=1, and no stale result ever appears.
- Illegal ALUType=4'd12 → result=0, zero=1, latency 1. A shift with shamt=0 (SLL 32'h1234_5678) → result=32'h1234_5678, latency 1.
